// File: rtl/uart_rx_io_pkg.sv
// uart_rx_pkg: shared constants and types for the UART receiver peripheral.
//   RX_DAT_bit / RX_STAT_bit : word-address bits that select the two registers
//   STAT_*                   : bit positions inside the RX_STAT read value
//   rx_state_t               : receiver FSM states
package uart_rx_pkg;

   localparam int RX_DAT_bit  = 3;
   localparam int RX_STAT_bit = 4;

   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_FRAME_ERR = 2;
   localparam int STAT_OVERRUN   = 3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_io_if.sv
// uart_rx_io_if: CPU IO bus as seen by the UART receiver.
//   IO_memAddr_i  : byte address (word address = bits [15:2])
//   IO_memRd_i    : one-cycle read strobe
//   IO_memRData_o : read data, combinational from the address
// master = CPU side, slave = peripheral side.
interface uart_rx_io_if;

   logic [31:0] IO_memAddr_i;
   logic        IO_memRd_i;
   logic [31:0] IO_memRData_o;

   modport master (output IO_memAddr_i, output IO_memRd_i, input IO_memRData_o);
   modport slave  (input IO_memAddr_i, input IO_memRd_i, output IO_memRData_o);

endinterface

// File: rtl/uart_rx_io_fifo.sv
// rx_fifo: synchronous FIFO, synchronous active-low reset.
//   clk_i, reset_i : clock, reset
//   push_i, data_i : write request and data
//   pop_i          : read request (ignored while empty)
//   head_o         : oldest entry
//   full_o, empty_o: occupancy flags
// A push while full is accepted only when a real pop happens in the same cycle.
module rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/uart_rx_io.sv
// uart_rx_io: memory-mapped 8N1 UART receiver with receive FIFO.
//   clk_i, reset_i : clock, synchronous active-low reset
//   rxd_i          : asynchronous serial input, idles high
//   bus            : IO bus slave (RX_DAT read pops, RX_STAT read clears errors)
//   rx_irq_o       : high while the FIFO holds data
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sample 8 data bits, LSB first, one per bit time
// STOP  | sample stop bit; push byte, or flag frame error
// BREAK | line held low after a bad stop bit; wait for it to go high
module uart_rx_io
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         rxd_i,
   uart_rx_io_if.slave  bus,
   output logic         rx_irq_o
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

   logic            rxd_meta, rxd_s;
   rx_state_t       state, state_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic [2:0]      bit_idx, bit_idx_nxt;
   logic [7:0]      shift, shift_nxt;
   logic            push, frame_set;
   logic            overrun, frame_err;
   logic            fifo_full, fifo_empty;
   logic [7:0]      fifo_head;
   logic            dat_sel, stat_sel, pop, stat_clr, ovr_set;
   logic            unused_addr;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= rxd_i;
         rxd_s    <= rxd_meta;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      push        = 1'b0;
      frame_set   = 1'b0;
      if (state != IDLE && state != BREAK && timer != '0)
         timer_nxt = timer - TW'(1);
      case (state)
         IDLE: begin
            if (!rxd_s) begin
               timer_nxt = HALF_LOAD;
               state_nxt = START;
            end
         end
         START: begin
            if (timer == '0) begin
               if (!rxd_s) begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
                  timer_nxt   = FULL_LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (timer == '0) begin
               shift_nxt   = {rxd_s, shift[7:1]};
               timer_nxt   = FULL_LOAD;
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (timer == '0) begin
               if (rxd_s) begin
                  push      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  frame_set = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            if (rxd_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push),
      .data_i  (shift),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Register selects are one-hot; RX_DAT wins if software sets both.
   assign dat_sel     = bus.IO_memAddr_i[2 + RX_DAT_bit];
   assign stat_sel    = bus.IO_memAddr_i[2 + RX_STAT_bit] && !dat_sel;
   assign pop         = bus.IO_memRd_i && dat_sel && !fifo_empty;
   assign stat_clr    = bus.IO_memRd_i && stat_sel;
   // A same-cycle pop frees the slot, so only a push into a still-full FIFO overruns.
   assign ovr_set     = push && fifo_full && !pop;
   assign rx_irq_o    = !fifo_empty;
   assign unused_addr = ^{bus.IO_memAddr_i[31:7], bus.IO_memAddr_i[4:0]};

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= ovr_set   || (overrun   && !stat_clr);
         frame_err <= frame_set || (frame_err && !stat_clr);
      end
   end

   always_comb begin
      bus.IO_memRData_o = '0;
      if (dat_sel) begin
         if (!fifo_empty) bus.IO_memRData_o[7:0] = fifo_head;
      end else if (stat_sel) begin
         bus.IO_memRData_o[STAT_OVERRUN]   = overrun;
         bus.IO_memRData_o[STAT_FRAME_ERR] = frame_err;
         bus.IO_memRData_o[STAT_FULL]      = fifo_full;
         bus.IO_memRData_o[STAT_NOT_EMPTY] = !fifo_empty;
      end
   end

endmodule
